// File: rtl/skrol_displej_pkg.sv
// ---------------------------------------------------------------------------
// skrol_displej_pkg
// Shared constants for the scrolling 4-digit 7-segment display slice.
//   NUM_DIGITS : number of multiplexed digits (4)
//   CHAR_W     : width of one segment code (8 bits)
//   SEG_BLANK  : segment code with every segment dark (active-low segments)
//   AN_OFF     : anode pattern with every digit switched off (active-low)
// anode_for() builds the active-low one-hot anode word for a digit slot,
// slot 0 being the leftmost digit on an[3].
// ---------------------------------------------------------------------------
package skrol_displej_pkg;

  localparam int              NUM_DIGITS = 4;
  localparam int              CHAR_W     = 8;
  localparam logic [7:0]      SEG_BLANK  = 8'hFF;
  localparam logic [3:0]      AN_OFF     = 4'b1111;

  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [1:0] slot);
    return ~(4'b1000 >> slot);
  endfunction

endpackage

// File: rtl/skrol_prescaler.sv
// ---------------------------------------------------------------------------
// skrol_prescaler
// Generic modulo-N counter: counts 0..N-1 on every cycle where step_i is
// high and wraps to 0. tc_o is a one-cycle pulse on the stepping cycle that
// sits at N-1, i.e. it marks the wrap edge.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (count -> 0)
//   step_i : advance the count this cycle
//   tc_o   : terminal-count pulse (combinational from count and step_i)
// ---------------------------------------------------------------------------
module skrol_prescaler #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_i,
  output logic tc_o
);

  localparam int            W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]  LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = step_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/skrol_displej.sv
// ---------------------------------------------------------------------------
// skrol_displej
// Multiplexed 4-digit display driver with horizontal text scrolling.
// A scan prescaler produces one digit tick every SCAN_DIV clocks; four digit
// ticks make a frame. Each frame the four segment codes on znakovi are
// latched into a frame buffer, so a frame is never torn. Every SCROLL_FRAMES
// frames the window position pozicija moves one character left or right.
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   en            : scroll enable (scanning always runs)
//   smer          : 0 = pozicija counts up, 1 = pozicija counts down
//   duzina_teksta : text length in characters
//   znakovi       : four segment codes, byte 0 = leftmost character
//   pozicija      : registered index of the leftmost displayed character
//   seg           : segment code of the active digit
//   an            : active-low one-hot digit anodes, an[3] = leftmost
// ---------------------------------------------------------------------------
module skrol_displej
  import skrol_displej_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         smer,
  input  logic [7:0]                   duzina_teksta,
  input  logic [NUM_DIGITS*CHAR_W-1:0] znakovi,
  output logic [7:0]                   pozicija,
  output logic [CHAR_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]        an
);

  logic digit_tick, frame_tick, scroll_tick;

  logic [1:0]                   d_q, d_d;
  logic [NUM_DIGITS*CHAR_W-1:0] buf_q, buf_d;
  logic [7:0]                   poz_q, poz_d;
  logic [CHAR_W-1:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;

  skrol_prescaler #(.N(SCAN_DIV)) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (1'b1),
    .tc_o   (digit_tick)
  );

  skrol_prescaler #(.N(SCROLL_FRAMES)) u_frame (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (frame_tick),
    .tc_o   (scroll_tick)
  );

  assign frame_tick = digit_tick && (d_q == 2'(NUM_DIGITS - 1));

  // Outputs are registered from the next-state values so that seg/an line
  // up with the slot the counters are entering. A digit tick means the
  // prescaler is about to read 0, which is the blanking (anti-ghost) count.
  always_comb begin
    d_d   = digit_tick ? d_q + 2'd1 : d_q;
    buf_d = frame_tick ? znakovi : buf_q;
    seg_d = buf_d[d_d*CHAR_W +: CHAR_W];
    an_d  = digit_tick ? AN_OFF : anode_for(d_d);
  end

  // Position update: an empty or shrunken text pins the window to 0 and
  // takes priority over a scroll tick arriving on the same edge.
  always_comb begin
    poz_d = poz_q;
    if (duzina_teksta == 8'd0 || poz_q >= duzina_teksta) begin
      poz_d = 8'd0;
    end else if (scroll_tick && en) begin
      if (!smer) begin
        poz_d = (poz_q == duzina_teksta - 8'd1) ? 8'd0 : poz_q + 8'd1;
      end else begin
        poz_d = (poz_q == 8'd0) ? duzina_teksta - 8'd1 : poz_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 2'd0;
      buf_q <= {NUM_DIGITS{SEG_BLANK}};
      poz_q <= 8'd0;
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
    end else begin
      d_q   <= d_d;
      buf_q <= buf_d;
      poz_q <= poz_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign pozicija = poz_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_skrol_displej.sv
// ---------------------------------------------------------------------------
// tb_skrol_displej
// Self-checking bench for skrol_displej with SCAN_DIV=4, SCROLL_FRAMES=2.
// A time-based reference model (cycles since reset) predicts pozicija, seg
// and an on every clock; table vectors and directed sequences add fixed
// expectations for scrolling, wrap, shrink, tearing and async reset.
// ---------------------------------------------------------------------------
module tb_skrol_displej;

  localparam int SD     = 4;
  localparam int SF     = 2;
  localparam int FRAME  = SD * 4;
  localparam int SCROLL = FRAME * SF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        smer;
  logic [7:0]  len;
  logic [31:0] zn;
  logic [7:0]  pozicija;
  logic [7:0]  seg;
  logic [3:0]  an;

  int nVectors = 0;
  int nMiscompares = 0;

  // model state: t = clock edges since reset release
  int          t;
  logic [31:0] mBuf;
  int          mPoz;

  typedef struct {
    logic [7:0] len;
    logic       en;
    logic       smer;
    int         cycles;
    logic [7:0] expPoz;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] anOn[4];
  logic [7:0] segSeq[4];

  always #5 clk = ~clk;

  skrol_displej #(.SCAN_DIV(SD), .SCROLL_FRAMES(SF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .smer          (smer),
    .duzina_teksta (len),
    .znakovi       (zn),
    .pozicija      (pozicija),
    .seg           (seg),
    .an            (an)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // expected anode word from the slot/phase derived from elapsed time
  function automatic logic [3:0] expAn();
    int phase = t % SD;
    int slot  = (t / SD) % 4;
    logic [3:0] r = 4'hF;
    if (phase != 0) r[3 - slot] = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] expSeg();
    int slot = (t / SD) % 4;
    return 8'(mBuf >> (8 * slot));
  endfunction

  task automatic checkModel();
    checkOutput("model_pozicija", {24'd0, pozicija}, mPoz);
    checkOutput("model_an", {28'd0, an}, {28'd0, expAn()});
    checkOutput("model_seg", {24'd0, seg}, {24'd0, expSeg()});
  endtask

  // advance the reference model by one clock edge using the inputs seen there
  task automatic modelEdge();
    bit frameEv  = (t % FRAME) == FRAME - 1;
    bit scrollEv = (t % SCROLL) == SCROLL - 1;
    int l = len;
    if (l == 0 || mPoz >= l) mPoz = 0;
    else if (scrollEv && en) mPoz = smer ? (mPoz + l - 1) % l : (mPoz + 1) % l;
    if (frameEv) mBuf = zn;
    t++;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkModel();
    end
  endtask

  // asynchronous reset pulse placed mid-cycle, with reset-value checks
  task automatic doReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_pozicija", {24'd0, pozicija}, 32'd0);
    checkOutput("reset_an", {28'd0, an}, 32'hF);
    checkOutput("reset_seg", {24'd0, seg}, 32'hFF);
    t = 0;
    mBuf = 32'hFFFF_FFFF;
    mPoz = 0;
    #1 rst_n = 1'b1;
    #1;
    checkModel();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'd11, 1'b1, 1'b0, 320, 8'd10};
    vecs[1] = '{8'd11, 1'b1, 1'b0, 352, 8'd0};
    vecs[2] = '{8'd11, 1'b1, 1'b1, 32,  8'd10};
    vecs[3] = '{8'd11, 1'b1, 1'b1, 64,  8'd9};
    vecs[4] = '{8'd11, 1'b0, 1'b0, 96,  8'd0};
    vecs[5] = '{8'd0,  1'b1, 1'b0, 96,  8'd0};
    vecs[6] = '{8'd1,  1'b1, 1'b1, 64,  8'd0};
    vecs[7] = '{8'd3,  1'b1, 1'b0, 128, 8'd1};
    anOn[0] = 4'b0111; anOn[1] = 4'b1011; anOn[2] = 4'b1101; anOn[3] = 4'b1110;
    segSeq[0] = 8'h11; segSeq[1] = 8'h22; segSeq[2] = 8'h33; segSeq[3] = 8'h44;

    rst_n = 1'b0;
    en = 1'b1; smer = 1'b0; len = 8'd11; zn = 32'h4433_2211;
    t = 0; mBuf = 32'hFFFF_FFFF; mPoz = 0;
    @(posedge clk);
    #1;
    doReset();

    // scan sequence after the first frame latch
    applyStimulus(16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("scan_an", {28'd0, an}, (i % 4 == 0) ? 32'hF : {28'd0, anOn[i / 4]});
      checkOutput("scan_seg", {24'd0, seg}, {24'd0, segSeq[i / 4]});
      if (i < 15) applyStimulus(1);
    end

    // new characters mid-frame must wait for the next frame latch
    applyStimulus(5);
    zn = 32'h8877_6655;
    applyStimulus(1);
    checkOutput("tear_old_seg", {24'd0, seg}, 32'h22);
    applyStimulus(11);
    checkOutput("tear_new_seg", {24'd0, seg}, 32'h55);

    // table vectors: scroll counts, wrap, direction, enable, degenerate lengths
    for (int v = 0; v < 8; v++) begin
      doReset();
      len = vecs[v].len; en = vecs[v].en; smer = vecs[v].smer;
      applyStimulus(vecs[v].cycles);
      checkOutput($sformatf("table%0d_pozicija", v), {24'd0, pozicija}, {24'd0, vecs[v].expPoz});
    end

    // length shrink overrides a coinciding scroll tick
    doReset();
    len = 8'd11; en = 1'b1; smer = 1'b0;
    applyStimulus(288);
    checkOutput("shrink_pre", {24'd0, pozicija}, 32'd9);
    applyStimulus(31);
    checkOutput("shrink_hold", {24'd0, pozicija}, 32'd9);
    len = 8'd5;
    applyStimulus(1);
    checkOutput("shrink_zero", {24'd0, pozicija}, 32'd0);

    // async reset mid-slot, then one blank cycle before the first digit
    len = 8'd11;
    applyStimulus(34);
    checkOutput("prereset_pozicija", {24'd0, pozicija}, 32'd1);
    doReset();
    checkOutput("release_blank_an", {28'd0, an}, 32'hF);
    applyStimulus(1);
    checkOutput("release_first_an", {28'd0, an}, 32'h7);
    checkOutput("release_first_seg", {24'd0, seg}, 32'hFF);

    // randomized run against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 31) == 0) len = 8'($urandom_range(0, 14));
      if ($urandom_range(0, 15) == 0) smer = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 6) == 0) zn = $urandom;
      applyStimulus(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/skrol_displej.md
SKROL_DISPLEJ -- requirements
Module: skrol_displej

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 2.
REQ-002 Parameter SCROLL_FRAMES, default 64: full 4-digit frames per scroll step, minimum 1.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scroll enable; 0 freezes pozicija, scanning continues.
REQ-006 smer  input  1  direction: 0 = pozicija increments, 1 = pozicija decrements.
REQ-007 duzina_teksta  input  8  text length in characters.
REQ-008 znakovi  input  32  four segment codes from the character-window block; byte 0 = leftmost character.
REQ-009 pozicija  output  8  registered index of the leftmost displayed character, fed to the character-window block.
REQ-010 seg  output  8  segment code of the active digit, passed unmodified.
REQ-011 an  output  4  digit anodes, active-low one-hot; an[3] = leftmost digit.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 and wraps; its terminal count is the digit tick.
REQ-013 Digit index d (0..3) advances on each digit tick and wraps 3->0; the 3->0 wrap is the frame tick.
REQ-014 On the frame tick, znakovi is latched into a 32-bit frame buffer; seg/an use only the buffer (no mid-frame tearing).
REQ-015 During slot d, seg = buffer[8d+7:8d] and an drives bit 3-d low; all other bits are high.
REQ-016 Anti-ghosting: in prescaler count 0 of every slot, an = 4'b1111 and seg still shows the new slot's code.
REQ-017 Frame counter counts frame ticks 0..SCROLL_FRAMES-1 and wraps; the wrap is the scroll tick. The counter runs regardless of en.
REQ-018 On a scroll tick with en=1 and smer=0, pozicija = (pozicija == duzina_teksta-1) ? 0 : pozicija+1.
REQ-019 On a scroll tick with en=1 and smer=1, pozicija = (pozicija == 0) ? duzina_teksta-1 : pozicija-1.
REQ-020 If duzina_teksta == 0, pozicija is forced to 0 every cycle, and scroll ticks have no effect.
REQ-021 If pozicija >= duzina_teksta (length shrank), pozicija is forced to 0 on the next clock; this overrides a simultaneous scroll tick.
REQ-022 Latency: pozicija updates on the same edge as the frame latch; the resulting characters are displayed from the following frame tick (one frame later).
REQ-023 smer or en changes take effect at the next scroll tick only.
REQ-024 All arithmetic is 8-bit unsigned; the prescaler and frame counter are sized with $clog2 of their parameters.

Reset
REQ-025 While rst_n=0: pozicija=0, an=4'b1111, seg=8'hFF, buffer=32'hFFFF_FFFF, prescaler=0, d=0, frame counter=0.
REQ-026 After rst_n deasserts mid-operation, scanning restarts at slot d=0 with a full SCAN_DIV period; no partial slot.

Structure
REQ-027 A shared package holds the digit-count constant (4), the character width (8), and the blank codes (SEG_BLANK=8'hFF, AN_OFF=4'b1111).
REQ-028 One sub-module, skrol_prescaler: a generic modulo-N counter with a terminal-count pulse, instanced for both the prescaler and the frame counter.
REQ-029 pozicija, seg and an are driven from registers; no combinational path from inputs to outputs.

Verification (SCAN_DIV=4, SCROLL_FRAMES=2)
REQ-030 Reset, then znakovi=32'h44332211 held -> after the first frame tick, an cycles 1111,0111 / 1111,1011 / 1111,1101 / 1111,1110 with seg 11,22,33,44 respectively.
REQ-031 duzina_teksta=11, en=1, smer=0 -> pozicija steps 0,1,...,10,0 with one step every 32 clk.
REQ-032 smer=1 from pozicija=0, duzina_teksta=11 -> next scroll tick gives pozicija=10, then 9.
REQ-033 pozicija=9, duzina_teksta changed to 5 -> pozicija=0 on the next clock, even if that clock carries a scroll tick.
REQ-034 znakovi changed mid-frame -> seg keeps the old bytes until the frame tick, then shows the new bytes.
REQ-035 rst_n pulsed low mid-slot, asynchronous to clk -> outputs immediately take reset values; after release, the first an=0111 appears after 1 blank cycle.
